// File: rtl/spi_sync_ram.sv
// Command-decoding RAM behind an SPI slave: address loads, writes and armed reads.
// Optional macro SPI_RAM_ADDR_AUTOINC_EN enables post-increment of both addresses.
module spi_sync_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] DATA_OUT = 2'd2;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 rd_armed;
  logic                 rx_valid_d;
  logic [1:0]           state;
  logic [1:0]           state_next;

  logic                 accept;
  logic [1:0]           cmd;
  logic [ADDR_SIZE-1:0] addr_in;

  // A frame executes once, on the rising edge of the level-type rx_valid.
  assign accept  = rx_valid & ~rx_valid_d;
  assign cmd     = din[9:8];
  assign addr_in = ADDR_SIZE'(din[7:0]);

  // tx_valid is simply "the last effective frame was a served read".
  assign tx_valid = (state == DATA_OUT);

  always_comb begin
    state_next = state;
    if (accept) begin
      case (cmd)
        CMD_RD_ADDR: state_next = ARMED;
        CMD_RD_DATA: begin
          // A rejected read leaves the sequencer (and tx_valid) untouched.
          if (rd_armed)
            state_next = DATA_OUT;
        end
        default: begin
          if (state == DATA_OUT)
            state_next = rd_armed ? ARMED : IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_d <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      rd_armed   <= 1'b0;
      state      <= IDLE;
      dout       <= 8'h00;
      cmd_err    <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;
      state      <= state_next;
      cmd_err    <= accept && (cmd == CMD_RD_DATA) && !rd_armed;
      if (accept) begin
        case (cmd)
          CMD_WR_ADDR: wr_addr <= addr_in;
          CMD_WR_DATA: begin
`ifdef SPI_RAM_ADDR_AUTOINC_EN
            wr_addr <= wr_addr + ADDR_SIZE'(1);
`endif
          end
          CMD_RD_ADDR: begin
            rd_addr  <= addr_in;
            rd_armed <= 1'b1;
          end
          default: begin
            if (rd_armed) begin
              dout <= mem[rd_addr];
`ifdef SPI_RAM_ADDR_AUTOINC_EN
              // Stay armed so consecutive RD_DATA frames stream sequential words.
              rd_addr <= rd_addr + ADDR_SIZE'(1);
`else
              rd_armed <= 1'b0;
`endif
            end
          end
        endcase
      end
    end
  end

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (accept && (cmd == CMD_WR_DATA))
      mem[wr_addr] <= din[7:0];
  end

endmodule

// File: tb/tb_spi_sync_ram.sv
// Directed bench for spi_sync_ram: frame-level reference model checked every cycle,
// plus literal expectations; honours SPI_RAM_ADDR_AUTOINC_EN when defined.
module tb_spi_sync_ram;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] din = 10'd0;
  logic       rx_valid = 1'b0;
  logic [7:0] dout;
  logic       tx_valid;
  logic       cmd_err;

  spi_sync_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Reference model: one update per executed frame.
  logic [7:0] mem_m [256];
  logic [7:0] m_wr, m_rd;
  bit         m_armed;
  logic [7:0] exp_dout;
  logic       exp_tx, exp_err;

  logic [7:0] last_dout;
  logic       last_tx, last_err, err_after;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h at %0t", name, got, want, $time);
    end
  endtask

  function automatic void model_reset();
    m_wr = 8'h00; m_rd = 8'h00; m_armed = 1'b0;
    exp_dout = 8'h00; exp_tx = 1'b0; exp_err = 1'b0;
  endfunction

  function automatic void model_apply(input logic [1:0] cmd, input logic [7:0] pl);
    case (cmd)
      2'b00: begin m_wr = pl; exp_tx = 1'b0; end
      2'b01: begin
        mem_m[m_wr] = pl;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
        m_wr = m_wr + 8'd1;
`endif
        exp_tx = 1'b0;
      end
      2'b10: begin m_rd = pl; m_armed = 1'b1; exp_tx = 1'b0; end
      default: begin
        if (m_armed) begin
          exp_dout = mem_m[m_rd];
          exp_tx   = 1'b1;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
          m_rd = m_rd + 8'd1;
`else
          m_armed = 1'b0;
`endif
        end else begin
          exp_err = 1'b1;
        end
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_dout", dout, exp_dout);
      chk("cyc_tx_valid", {7'd0, tx_valid}, {7'd0, exp_tx});
      chk("cyc_cmd_err", {7'd0, cmd_err}, {7'd0, exp_err});
    end
  end

  // Entered and left at posedge+1; rx_valid high for 'hold' edges, then low for one.
  task automatic frame(input logic [1:0] cmd, input logic [7:0] pl, input int hold);
    din = {cmd, pl};
    rx_valid = 1'b1;
    @(posedge clk); #1;
    model_apply(cmd, pl);
    last_dout = dout; last_tx = tx_valid; last_err = cmd_err;
    for (int i = 1; i <= hold; i++) begin
      if (i == hold) rx_valid = 1'b0;
      @(posedge clk); #1;
      exp_err = 1'b0;
      if (i == 1) err_after = cmd_err;
    end
    $display("frame cmd=%0d payload=%02h hold=%0d -> dout=%02h tx_valid=%0b cmd_err=%0b",
             cmd, pl, hold, last_dout, last_tx, last_err);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    $display("reset pulse applied");
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    check_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle after reset: model checks every cycle, literals pin the reset values.
    repeat (20) @(posedge clk);
    #1;
    chk("rst_dout", dout, 8'h00);
    chk("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    chk("rst_cmd_err", {7'd0, cmd_err}, 8'h00);

    // Basic write then read.
    frame(2'b00, 8'h3C, 1);
    frame(2'b01, 8'hA5, 1);
    frame(2'b10, 8'h3C, 1);
    frame(2'b11, 8'h00, 1);
    chk("wr_rd_dout", last_dout, 8'hA5);
    chk("wr_rd_tx", {7'd0, last_tx}, 8'h01);
    frame(2'b00, 8'h10, 1);
    chk("tx_drop", {7'd0, last_tx}, 8'h00);
    chk("dout_hold", last_dout, 8'hA5);

    // Held rx_valid executes once.
    frame(2'b00, 8'h50, 1);
    frame(2'b01, 8'h11, 10);
    frame(2'b01, 8'h22, 1);
    frame(2'b10, 8'h50, 1);
    frame(2'b11, 8'h00, 1);
`ifdef SPI_RAM_ADDR_AUTOINC_EN
    chk("held_first", last_dout, 8'h11);
    frame(2'b11, 8'h00, 1);
    chk("held_second", last_dout, 8'h22);
`else
    chk("held_first", last_dout, 8'h22);
`endif

    // Illegal read right after reset, issued in the first cycle after release.
    do_reset();
    frame(2'b11, 8'h00, 1);
    chk("ill_err", {7'd0, last_err}, 8'h01);
    chk("ill_err_pulse", {7'd0, err_after}, 8'h00);
    chk("ill_tx", {7'd0, last_tx}, 8'h00);
    chk("ill_dout", last_dout, 8'h00);

    // Address wrap at the top of memory.
    frame(2'b00, 8'hFF, 1);
    frame(2'b01, 8'h77, 1);
    frame(2'b01, 8'h88, 1);
    frame(2'b10, 8'hFF, 1);
    frame(2'b11, 8'h00, 1);
`ifdef SPI_RAM_ADDR_AUTOINC_EN
    chk("wrap_first", last_dout, 8'h77);
    frame(2'b11, 8'h00, 1);
    chk("wrap_second", last_dout, 8'h88);
    chk("wrap_no_err", {7'd0, last_err}, 8'h00);
`else
    chk("wrap_first", last_dout, 8'h88);
    frame(2'b11, 8'h00, 1);
    chk("wrap_second_err", {7'd0, last_err}, 8'h01);
`endif

    // Reset between RD_ADDR and RD_DATA drops the pending read.
    frame(2'b10, 8'hFF, 1);
    do_reset();
    frame(2'b11, 8'h00, 1);
    chk("midrst_err", {7'd0, last_err}, 8'h01);
    chk("midrst_tx", {7'd0, last_tx}, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
